// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial signed adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } addsub_st_e;

    // Width of the step counter: enough to count WIDTH/DIGIT steps, never less than one bit.
    function automatic int cnt_w(input int width, input int digit);
        int steps;
        steps = width / digit;
        if (steps <= 2) begin
            return 1;
        end
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    modport master (
        output start_i, sub_i, a_i, b_i,
        input  ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i,
        output ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the final digit.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    // Ripple the carry through the digit, remembering the carry entering the top bit.
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        cmsb  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            cmsb  = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial signed adder/subtractor: captures operands on start, consumes
// DIGIT bits per clock LSB first, and presents sum/carry/overflow with a done pulse.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    addsub_serial_if.slave bus
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_w(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end

    addsub_st_e       state;
    addsub_st_e       next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .s    (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept only in IDLE, leave RUN after the last digit, DONE lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.start_i) next_state = ST_RUN;
            ST_RUN:  if (cnt == LAST) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the state register only.
    always_comb begin
        bus.ready_o = (state == ST_IDLE);
        bus.busy_o  = (state == ST_RUN);
        bus.done_o  = (state == ST_DONE);
    end

    // Result shift register takes the new digit at its top so the word lands LSB-aligned after the last step.
    always_comb begin
        res_next = res_sh >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dsum;
    end

    // Datapath: load operands (B pre-inverted and carry seeded for subtract), then shift one digit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        a_sh   <= bus.a_i;
                        b_sh   <= bus.b_i ^ {WIDTH{bus.sub_i}};
                        res_sh <= '0;
                        carry  <= bus.sub_i;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= dcout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= res_next;
                        cout_q <= dcout;
                        ovf_q  <= dcmsb ^ dcout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
    assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: directed vector table on an 8-bit/1-bit instance,
// multi-cycle corner sequences, and random ops on several WIDTH/DIGIT instances.
module tb_addsub_serial;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic goRand   = 1'b0;
    logic [4:0] genDone = '0;
    res_t expQ[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(8)) bus8 ();

    addsub_serial #(
        .WIDTH (8),
        .DIGIT (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t refModel(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub, input int w);
        logic [32:0] mask;
        logic [32:0] bb;
        logic [32:0] t;
        res_t        r;
        mask   = (33'd1 << w) - 33'd1;
        bb     = {1'b0, (sub ? ~b : b)} & mask;
        t      = ({1'b0, a} & mask) + bb + {32'd0, sub};
        r.sum  = t[31:0] & mask[31:0];
        r.cout = t[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic applyStimulus(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input res_t exp);
        @(negedge clk);
        checkOutput("accept.ready", 32'(bus8.ready_o), 32'd1);
        bus8.start_i = 1'b1;
        bus8.sub_i   = sub;
        bus8.a_i     = a;
        bus8.b_i     = b;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        bus8.a_i     = ~a;
        bus8.b_i     = a ^ b;
        bus8.sub_i   = ~sub;
    endtask

    task automatic runOp(input string tag, input bit inject);
        int         cyc;
        int         busyCnt;
        bit         held;
        logic [7:0] prevSum;
        res_t       exp;
        cyc     = 1;
        busyCnt = 0;
        held    = 1'b1;
        @(negedge clk);
        prevSum = bus8.sum_o;
        while (bus8.done_o !== 1'b1 && cyc < 64) begin
            if (bus8.busy_o === 1'b1) busyCnt++;
            if (bus8.sum_o !== prevSum) held = 1'b0;
            if (inject && cyc == 3) begin
                bus8.start_i = 1'b1;
                bus8.sub_i   = 1'b0;
                bus8.a_i     = 8'hFF;
                bus8.b_i     = 8'hFF;
            end
            if (inject && cyc == 4) bus8.start_i = 1'b0;
            @(negedge clk);
            cyc++;
        end
        exp = expQ.pop_front();
        checkOutput({tag, ".latency"}, 32'(cyc), 32'd9);
        checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'd8);
        checkOutput({tag, ".heldDuringRun"}, 32'(held), 32'd1);
        checkOutput({tag, ".sum"}, 32'(bus8.sum_o), exp.sum);
        checkOutput({tag, ".cout"}, 32'(bus8.cout_o), 32'(exp.cout));
        checkOutput({tag, ".ovf"}, 32'(bus8.ovf_o), 32'(exp.ovf));
        if (inject) begin
            bus8.start_i = 1'b1;
            bus8.a_i     = 8'hFF;
            bus8.b_i     = 8'hFF;
        end
        @(negedge clk);
        bus8.start_i = 1'b0;
        checkOutput({tag, ".donePulse"}, 32'(bus8.done_o), 32'd0);
        checkOutput({tag, ".readyAfter"}, 32'(bus8.ready_o), 32'd1);
        checkOutput({tag, ".busyAfter"}, 32'(bus8.busy_o), 32'd0);
    endtask

    // Random and boundary ops on a spread of WIDTH/DIGIT shapes, each with its own scoreboard.
    for (genvar g = 0; g < 5; g++) begin : g_rand
        localparam int GW = (g == 0) ? 8 : 16;
        localparam int GD = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 4 : 16;
        localparam int GN = GW / GD;

        addsub_serial_if #(.WIDTH(GW)) gbus ();

        addsub_serial #(
            .WIDTH (GW),
            .DIGIT (GD)
        ) gdut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (gbus)
        );

        res_t q[$];

        initial begin
            gbus.start_i = 1'b0;
            gbus.sub_i   = 1'b0;
            gbus.a_i     = '0;
            gbus.b_i     = '0;
            wait (goRand === 1'b1);
            for (int k = 0; k < 25; k++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                logic        rs;
                res_t        e;
                int          cyc;
                string       tag;
                if (k == 0) begin
                    ra = (32'd1 << GW) - 32'd1;
                    rb = 32'd1;
                    rs = 1'b0;
                end else begin
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(1));
                end
                tag = $sformatf("w%0dd%0d.op%0d", GW, GD, k);
                @(negedge clk);
                gbus.start_i = 1'b1;
                gbus.sub_i   = rs;
                gbus.a_i     = ra[GW-1:0];
                gbus.b_i     = rb[GW-1:0];
                q.push_back(refModel(ra, rb, rs, GW));
                @(posedge clk);
                #1;
                gbus.start_i = 1'b0;
                gbus.a_i     = ~gbus.a_i;
                cyc = 1;
                @(negedge clk);
                while (gbus.done_o !== 1'b1 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                end
                e = q.pop_front();
                checkOutput({tag, ".latency"}, 32'(cyc), 32'(GN + 1));
                checkOutput({tag, ".sum"}, 32'(gbus.sum_o), e.sum);
                checkOutput({tag, ".cout"}, 32'(gbus.cout_o), 32'(e.cout));
                checkOutput({tag, ".ovf"}, 32'(gbus.ovf_o), 32'(e.ovf));
                @(negedge clk);
            end
            genDone[g] = 1'b1;
        end
    end

    initial begin
        bit noDone;

        vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 8'h80, 8'h7F, 8'h01, 1'b1, 1'b1};

        rst_n        = 1'b0;
        bus8.start_i = 1'b0;
        bus8.sub_i   = 1'b0;
        bus8.a_i     = '0;
        bus8.b_i     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.ready", 32'(bus8.ready_o), 32'd1);
        checkOutput("reset.busy", 32'(bus8.busy_o), 32'd0);
        checkOutput("reset.done", 32'(bus8.done_o), 32'd0);
        checkOutput("reset.sum", 32'(bus8.sum_o), 32'd0);
        checkOutput("reset.cout", 32'(bus8.cout_o), 32'd0);
        checkOutput("reset.ovf", 32'(bus8.ovf_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sub, vecs[i].a, vecs[i].b,
                          '{sum: {24'd0, vecs[i].sum}, cout: vecs[i].cout, ovf: vecs[i].ovf});
            runOp($sformatf("vec%0d", i), 1'b0);
        end

        // start pulses during RUN and DONE must not disturb the op in flight
        applyStimulus(1'b0, 8'h05, 8'h03, '{sum: 32'h08, cout: 1'b0, ovf: 1'b0});
        runOp("ignore", 1'b1);
        @(negedge clk);
        checkOutput("ignore.stillIdle", 32'(bus8.busy_o), 32'd0);
        checkOutput("ignore.sumHeld", 32'(bus8.sum_o), 32'h08);

        // reset in RUN cycle 4 aborts the op
        @(negedge clk);
        bus8.start_i = 1'b1;
        bus8.sub_i   = 1'b0;
        bus8.a_i     = 8'h7F;
        bus8.b_i     = 8'h01;
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort.busyBefore", 32'(bus8.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.ready", 32'(bus8.ready_o), 32'd1);
        checkOutput("abort.busy", 32'(bus8.busy_o), 32'd0);
        checkOutput("abort.done", 32'(bus8.done_o), 32'd0);
        checkOutput("abort.sum", 32'(bus8.sum_o), 32'd0);
        checkOutput("abort.cout", 32'(bus8.cout_o), 32'd0);
        checkOutput("abort.ovf", 32'(bus8.ovf_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        noDone = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done_o !== 1'b0) noDone = 1'b0;
        end
        checkOutput("abort.noDone", 32'(noDone), 32'd1);
        applyStimulus(1'b0, 8'h10, 8'h20, '{sum: 32'h30, cout: 1'b0, ovf: 1'b0});
        runOp("afterAbort", 1'b0);

        goRand = 1'b1;
        for (int t = 0; t < 20000 && genDone !== 5'h1F; t++) @(negedge clk);
        checkOutput("rand.complete", 32'(genDone), 32'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
